// File: rtl/tcbm_drive_link.sv
// rtl/tcbm_drive_link.sv - drive-side TCBM DAV/ACK handshake engine with code decode and byte streams
module tcbm_drive_link #(
    parameter int TIMEOUT     = 65535,
    parameter int SYNC_STAGES = 2
) (
    input  logic       phi2,
    input  logic       _reset,
    input  logic [7:0] tcbm_data_in,
    output logic [7:0] tcbm_data_out,
    output logic       tcbm_data_oe,
    input  logic       tcbm_dav,
    output logic       tcbm_ack,
    output logic [1:0] tcbm_st,
    output logic [7:0] m_data,
    output logic       m_cmd,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       err,
    input  logic       err_clr,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, CODE_ACK, PARAM_WAIT, PARAM_PUSH, PARAM_ACK, RD_WAIT, RD_ACK, RD_REL
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    logic [SYNC_STAGES-1:0]      dav_sync;
    logic [SYNC_STAGES-1:0][7:0] data_sync;
    logic                        dav_s;
    logic [7:0]                  data_s;

    state_t      state, state_n;
    logic [7:0]  code_q, code_n;
    logic [15:0] tcnt, cnt_n;
    logic        prem, prem_n;
    logic        ack_n, oe_n, mvalid_n, mcmd_n, sready_n, err_set, err_n;
    logic [7:0]  dout_n, mdata_n;
    logic [1:0]  st_n;

    // Sync chains idle at the released-strobe level so reset never looks like a DAV.
    always_ff @(posedge phi2) begin
        if (!_reset) begin
            dav_sync  <= '1;
            data_sync <= '0;
        end else begin
            dav_sync  <= {dav_sync[SYNC_STAGES-2:0], tcbm_dav};
            data_sync <= {data_sync[SYNC_STAGES-2:0], tcbm_data_in};
        end
    end

    assign dav_s  = dav_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign busy   = (state != IDLE);

    always_ff @(posedge phi2) begin
        if (!_reset) begin
            state         <= IDLE;
            code_q        <= '0;
            tcnt          <= '0;
            prem          <= 1'b0;
            tcbm_ack      <= 1'b1;
            tcbm_data_oe  <= 1'b0;
            tcbm_data_out <= '0;
            tcbm_st       <= 2'b00;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_cmd         <= 1'b0;
            s_ready       <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_n;
            code_q        <= code_n;
            tcnt          <= cnt_n;
            prem          <= prem_n;
            tcbm_ack      <= ack_n;
            tcbm_data_oe  <= oe_n;
            tcbm_data_out <= dout_n;
            tcbm_st       <= st_n;
            m_valid       <= mvalid_n;
            m_data        <= mdata_n;
            m_cmd         <= mcmd_n;
            s_ready       <= sready_n;
            err           <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        code_n   = code_q;
        cnt_n    = tcnt;
        prem_n   = prem;
        ack_n    = tcbm_ack;
        oe_n     = tcbm_data_oe;
        dout_n   = tcbm_data_out;
        st_n     = tcbm_st;
        mvalid_n = m_valid;
        mdata_n  = m_data;
        mcmd_n   = m_cmd;
        sready_n = 1'b0;
        err_set  = 1'b0;

        case (state)
            IDLE: begin
                if (!dav_s) begin
                    code_n  = data_s;
                    ack_n   = 1'b0;
                    state_n = CODE_ACK;
                    if (data_s == 8'h81 || data_s == 8'h82 || data_s == 8'h83) begin
                        st_n = 2'b00;
                    end else begin
                        st_n    = 2'b11;
                        err_set = 1'b1;
                    end
                end
            end
            CODE_ACK: begin
                if (dav_s) begin
                    ack_n = 1'b1;
                    case (code_q)
                        8'h81, 8'h82: state_n = PARAM_WAIT;
                        8'h83: begin
                            state_n = RD_WAIT;
                            cnt_n   = '0;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            PARAM_WAIT: begin
                if (!dav_s) begin
                    mdata_n  = data_s;
                    mcmd_n   = (code_q == 8'h81);
                    mvalid_n = 1'b1;
                    prem_n   = 1'b0;
                    state_n  = PARAM_PUSH;
                end
            end
            PARAM_PUSH: begin
                // Strobe released before we acknowledged: flag it, still hand the byte over.
                if (dav_s && !prem) begin
                    err_set = 1'b1;
                    prem_n  = 1'b1;
                end
                if (m_ready) begin
                    mvalid_n = 1'b0;
                    if (prem || dav_s) begin
                        state_n = IDLE;
                    end else begin
                        ack_n   = 1'b0;
                        state_n = PARAM_ACK;
                    end
                end
            end
            PARAM_ACK: begin
                if (dav_s) begin
                    ack_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_WAIT: begin
                // OE goes up one cycle ahead of ACK so the byte is settled on the cable.
                if (tcbm_data_oe) begin
                    ack_n   = 1'b0;
                    state_n = RD_ACK;
                end else if (dav_s) begin
                    cnt_n = '0;
                end else if (s_valid) begin
                    dout_n   = s_data;
                    st_n     = s_last ? 2'b10 : 2'b00;
                    sready_n = 1'b1;
                    oe_n     = 1'b1;
                end else if (tcnt == TIMEOUT_C) begin
                    dout_n = 8'h00;
                    st_n   = 2'b01;
                    oe_n   = 1'b1;
                end else begin
                    cnt_n = tcnt + 16'd1;
                end
            end
            RD_ACK: begin
                if (dav_s) begin
                    ack_n   = 1'b1;
                    oe_n    = 1'b0;
                    state_n = RD_REL;
                end
            end
            RD_REL:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        err_n = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
    end

endmodule
